// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - fetch PC generator with tagged 2-bit BHT/BTB and mispredict redirect
// Optional performance counters are built when BPU_PERF_EN is defined.
module branch_predict_unit #(
    parameter int              XLEN        = 32,
    parameter int              BHT_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              PERF_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            res_valid_i,
    input  logic            res_is_branch_i,
    input  logic            res_is_jump_i,
    input  logic [XLEN-1:0] res_pc_i,
    input  logic [XLEN-1:0] res_target_i,
    input  logic            res_taken_i,
    input  logic            res_pred_taken_i,
    input  logic [XLEN-1:0] res_pred_target_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
`ifdef BPU_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_resolved_o,
    output logic [PERF_W-1:0] perf_mispred_o
`endif
);

    localparam int IDX  = $clog2(BHT_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [XLEN-1:0]        r_fetch_pc;
    logic [BHT_ENTRIES-1:0] r_valid;
    logic [1:0]             r_ctr    [BHT_ENTRIES];
    logic [TAGW-1:0]        r_tag    [BHT_ENTRIES];
    logic [XLEN-1:0]        r_target [BHT_ENTRIES];

    logic [IDX-1:0]  w_f_idx;
    logic [TAGW-1:0] w_f_tag;
    logic            w_f_hit;
    logic [IDX-1:0]  w_r_idx;
    logic [TAGW-1:0] w_r_tag;
    logic            w_r_hit;
    logic            w_r_ctl;
    logic            w_mispred;
    logic            w_wr_entry;
    logic            w_ctr_we;
    logic [1:0]      w_ctr_cur;
    logic [1:0]      w_ctr_next;
    logic [XLEN-1:0] w_next_pc;

    // Fetch-side lookup reads the registered table, so a same-cycle update is not seen.
    assign w_f_idx       = r_fetch_pc[IDX+1:2];
    assign w_f_tag       = r_fetch_pc[XLEN-1:IDX+2];
    assign w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign pred_taken_o  = w_f_hit && r_ctr[w_f_idx][1];
    assign pred_target_o = pred_taken_o ? r_target[w_f_idx] : r_fetch_pc + XLEN'(4);
    assign fetch_pc_o    = r_fetch_pc;

    assign w_r_idx   = res_pc_i[IDX+1:2];
    assign w_r_tag   = res_pc_i[XLEN-1:IDX+2];
    assign w_r_hit   = r_valid[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
    assign w_r_ctl   = res_valid_i && (res_is_branch_i || res_is_jump_i);
    assign w_mispred = w_r_ctl && ((res_taken_i != res_pred_taken_i) ||
                                   (res_taken_i && (res_target_i != res_pred_target_i)));

    assign redirect_o    = w_mispred;
    assign redirect_pc_o = res_taken_i ? res_target_i : res_pc_i + XLEN'(4);

    // Any taken resolve (or jump) writes valid/tag/target; a hit keeps its tag unchanged.
    assign w_wr_entry = w_r_ctl && (res_is_jump_i || res_taken_i);
    assign w_ctr_we   = w_r_ctl && (res_is_jump_i || w_r_hit || res_taken_i);
    assign w_ctr_cur  = r_ctr[w_r_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (res_is_jump_i) begin
            w_ctr_next = 2'b11;
        end else if (!w_r_hit) begin
            w_ctr_next = 2'b10;
        end else if (res_taken_i) begin
            w_ctr_next = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1;
        end else begin
            w_ctr_next = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1;
        end
    end

    always_comb begin
        w_next_pc = pred_target_o;
        if (redirect_o) begin
            w_next_pc = redirect_pc_o;
        end else if (stall_i) begin
            w_next_pc = r_fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_valid    <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else begin
            r_fetch_pc <= w_next_pc;
            if (w_wr_entry) begin
                r_valid[w_r_idx] <= 1'b1;
            end
            if (w_ctr_we) begin
                r_ctr[w_r_idx] <= w_ctr_next;
            end
        end
    end

    // Tag/target need no reset; valid gates them, and writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_entry) begin
            r_tag[w_r_idx]    <= w_r_tag;
            r_target[w_r_idx] <= res_target_i;
        end
    end

`ifdef BPU_PERF_EN
    logic [PERF_W-1:0] r_perf_resolved;
    logic [PERF_W-1:0] r_perf_mispred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_resolved <= '0;
            r_perf_mispred  <= '0;
        end else begin
            if (w_r_ctl && (r_perf_resolved != {PERF_W{1'b1}})) begin
                r_perf_resolved <= r_perf_resolved + PERF_W'(1);
            end
            if (w_mispred && (r_perf_mispred != {PERF_W{1'b1}})) begin
                r_perf_mispred <= r_perf_mispred + PERF_W'(1);
            end
        end
    end

    assign perf_resolved_o = r_perf_resolved;
    assign perf_mispred_o  = r_perf_mispred;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic [31:0] fetch_pc_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        res_valid_i;
    logic        res_is_branch_i;
    logic        res_is_jump_i;
    logic [31:0] res_pc_i;
    logic [31:0] res_target_i;
    logic        res_taken_i;
    logic        res_pred_taken_i;
    logic [31:0] res_pred_target_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
`ifdef BPU_PERF_EN
    logic [31:0] perf_resolved_o;
    logic [31:0] perf_mispred_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_predict_unit #(
        .XLEN(32), .BHT_ENTRIES(64), .RESET_PC(32'h0000_0100), .PERF_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .fetch_pc_o(fetch_pc_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .res_valid_i(res_valid_i), .res_is_branch_i(res_is_branch_i), .res_is_jump_i(res_is_jump_i),
        .res_pc_i(res_pc_i), .res_target_i(res_target_i), .res_taken_i(res_taken_i),
        .res_pred_taken_i(res_pred_taken_i), .res_pred_target_i(res_pred_target_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
`ifdef BPU_PERF_EN
        , .perf_resolved_o(perf_resolved_o), .perf_mispred_o(perf_mispred_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res_valid_i = 0; res_is_branch_i = 0; res_is_jump_i = 0; res_taken_i = 0;
        res_pred_taken_i = 0; res_pc_i = '0; res_target_i = '0; res_pred_target_i = '0;
    endtask

    task automatic resolve(input logic br, input logic jp, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic tk, input logic ptk,
                           input logic [31:0] ptgt);
        res_valid_i = 1; res_is_branch_i = br; res_is_jump_i = jp; res_pc_i = pc;
        res_target_i = tgt; res_taken_i = tk; res_pred_taken_i = ptk; res_pred_target_i = ptgt;
        #1;
    endtask

    initial begin
        rst_n = 1; stall_i = 0;
        idle();
        #2 rst_n = 0;
        #1;
        chk("rst_fetch_pc", fetch_pc_o, 32'h100);
        chk("rst_pred_taken", {31'b0, pred_taken_o}, 32'h0);
        chk("rst_redirect", {31'b0, redirect_o}, 32'h0);
        step(); step();
        chk("rst_hold_pc", fetch_pc_o, 32'h100);
        rst_n = 1;
        step(); chk("seq_104", fetch_pc_o, 32'h104); chk("seq_pt0", {31'b0, pred_taken_o}, 32'h0);
        step(); chk("seq_108", fetch_pc_o, 32'h108); chk("seq_pt1", {31'b0, pred_taken_o}, 32'h0);
        step(); chk("seq_10c", fetch_pc_o, 32'h10C); chk("seq_pt2", {31'b0, pred_taken_o}, 32'h0);

        resolve(0, 0, 32'h10C, 32'h900, 1, 0, 32'h0);
        chk("noflag_redirect", {31'b0, redirect_o}, 32'h0);
        step(); idle();
        chk("noflag_pc", fetch_pc_o, 32'h110);

        resolve(1, 0, 32'h200, 32'h180, 1, 0, 32'h0);
        chk("alloc_redirect", {31'b0, redirect_o}, 32'h1);
        chk("alloc_rpc", redirect_pc_o, 32'h180);
        step(); idle();
        chk("alloc_fetch", fetch_pc_o, 32'h180);
        chk("miss_180", {31'b0, pred_taken_o}, 32'h0);

        resolve(1, 0, 32'h1FC, 32'h0, 0, 1, 32'h0);
        chk("to200_rpc", redirect_pc_o, 32'h200);
        step(); idle();
        chk("at200_pc", fetch_pc_o, 32'h200);
        chk("at200_pt", {31'b0, pred_taken_o}, 32'h1);
        chk("at200_tgt", pred_target_o, 32'h180);

        resolve(1, 0, 32'h200, 32'h180, 0, 1, 32'h180);
        chk("nt1_redirect", {31'b0, redirect_o}, 32'h1);
        chk("nt1_rpc", redirect_pc_o, 32'h204);
        chk("rbw_pt", {31'b0, pred_taken_o}, 32'h1);
        step(); idle();
        chk("nt1_fetch", fetch_pc_o, 32'h204);

        resolve(1, 0, 32'h200, 32'h180, 0, 0, 32'h0);
        chk("nt2_redirect", {31'b0, redirect_o}, 32'h0);
        step(); idle();
        chk("nt2_fetch", fetch_pc_o, 32'h208);

        resolve(1, 0, 32'h1FC, 32'h0, 0, 1, 32'h0);
        step(); idle();
        chk("ctr0_pc", fetch_pc_o, 32'h200);
        chk("ctr0_pt", {31'b0, pred_taken_o}, 32'h0);
        chk("ctr0_tgt", pred_target_o, 32'h204);

        stall_i = 1;
        resolve(1, 0, 32'h3F0, 32'h400, 1, 0, 32'h0);
        chk("stall_redirect", {31'b0, redirect_o}, 32'h1);
        step(); idle();
        chk("stall_redir_pc", fetch_pc_o, 32'h400);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_hold", fetch_pc_o, 32'h400);
        end
        stall_i = 0;
        step();
        chk("unstall_pc", fetch_pc_o, 32'h404);

        resolve(1, 0, 32'h10, 32'hFFFF_FFFC, 1, 0, 32'h0);
        step(); idle();
        chk("top_pc", fetch_pc_o, 32'hFFFF_FFFC);
        chk("top_pt", {31'b0, pred_taken_o}, 32'h0);
        chk("top_tgt", pred_target_o, 32'h0);
        step();
        chk("wrap_pc", fetch_pc_o, 32'h0);

        resolve(0, 1, 32'h100, 32'h500, 1, 0, 32'h0);
        chk("jmp_rpc", redirect_pc_o, 32'h500);
        chk("jmp_same_cycle_pt", {31'b0, pred_taken_o}, 32'h0);
        step(); idle();
        chk("jmp_fetch", fetch_pc_o, 32'h500);
        chk("alias_500_pt", {31'b0, pred_taken_o}, 32'h0);

        resolve(1, 0, 32'hFFFF_FFFC, 32'h0, 0, 1, 32'h0);
        chk("rpc_wrap", redirect_pc_o, 32'h0);
        step(); idle();
        chk("alias_0_pc", fetch_pc_o, 32'h0);
        chk("alias_0_pt", {31'b0, pred_taken_o}, 32'h0);
        chk("alias_0_tgt", pred_target_o, 32'h4);

        resolve(1, 0, 32'hFC, 32'h0, 0, 1, 32'h0);
        step(); idle();
        chk("jmp_hit_pc", fetch_pc_o, 32'h100);
        chk("jmp_hit_pt", {31'b0, pred_taken_o}, 32'h1);
        chk("jmp_hit_tgt", pred_target_o, 32'h500);

        resolve(1, 0, 32'h600, 32'h700, 1, 0, 32'h0);
        rst_n = 0;
        #1;
        chk("midrst_pc", fetch_pc_o, 32'h100);
        chk("midrst_tbl_clear", {31'b0, pred_taken_o}, 32'h0);
        chk("midrst_redirect_comb", {31'b0, redirect_o}, 32'h1);
`ifdef BPU_PERF_EN
        chk("midrst_perf_res", perf_resolved_o, 32'h0);
`endif
        step();
        chk("midrst_discard", fetch_pc_o, 32'h100);
        idle();
        rst_n = 1;
        step();
        chk("post_rst_edge", fetch_pc_o, 32'h104);

        resolve(1, 0, 32'h800, 32'h900, 1, 0, 32'h0);
        chk("p1_redirect", {31'b0, redirect_o}, 32'h1);
        step(); idle();
        resolve(1, 0, 32'h804, 32'h0, 0, 0, 32'h0);
        chk("p2_redirect", {31'b0, redirect_o}, 32'h0);
        step(); idle();
        resolve(0, 1, 32'h808, 32'hA00, 1, 1, 32'hA00);
        chk("p3_redirect", {31'b0, redirect_o}, 32'h0);
        step(); idle();
        resolve(1, 0, 32'h80C, 32'h900, 1, 1, 32'h950);
        chk("p4_redirect", {31'b0, redirect_o}, 32'h1);
        chk("p4_rpc", redirect_pc_o, 32'h900);
        step(); idle();
        resolve(0, 0, 32'h810, 32'h0, 1, 0, 32'h0);
        step(); idle();
        resolve(1, 0, 32'h814, 32'h0, 0, 0, 32'h0);
        chk("p5_redirect", {31'b0, redirect_o}, 32'h0);
        step(); idle();
`ifdef BPU_PERF_EN
        chk("perf_resolved", perf_resolved_o, 32'd5);
        chk("perf_mispred", perf_mispred_o, 32'd2);
        rst_n = 0;
        #1;
        chk("perf_res_rst", perf_resolved_o, 32'd0);
        chk("perf_mis_rst", perf_mispred_o, 32'd0);
        rst_n = 1;
`endif
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
